// File: rtl/asic_dmux_pipe_pkg.sv
// rtl/asic_dmux_pipe_pkg.sv - shared state encodings and one-hot helper for the mux pipeline
// Contents:
//   skid_state_t : skid buffer occupancy (EMPTY / ONE / FULL)
//   is_onehot()  : popcount-is-one test, usable by any one-hot block up to ONEHOT_MAX_W bits
package asic_dmux_pipe_pkg;

    localparam int ONEHOT_MAX_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/asic_dmux_pipe_if.sv
// rtl/asic_dmux_pipe_if.sv - select/data/handshake bundle for asic_dmux_pipe
// Signals:
//   sel[N], in[N*DW], in_valid, in_ready : input side (channel 0 in LSBs of in)
//   out[DW], out_valid, out_ready        : registered output side
//   err, err_clear                       : sticky select error and its clear
// Modports: master drives the request side, slave is the mux pipeline.
interface asic_dmux_pipe_if #(
    parameter int N  = 4,
    parameter int DW = 1
);

    logic [N-1:0]    sel;
    logic [N*DW-1:0] in;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out;
    logic            out_valid;
    logic            out_ready;
    logic            err;
    logic            err_clear;

    modport master (
        output sel, in, in_valid, out_ready, err_clear,
        input  in_ready, out, out_valid, err
    );

    modport slave (
        input  sel, in, in_valid, out_ready, err_clear,
        output in_ready, out, out_valid, err
    );

endinterface

// File: rtl/asic_dmux_skid.sv
// rtl/asic_dmux_skid.sv - 2-entry skid buffer with valid/ready state machine
// Ports:
//   clk, nreset                         : clock, asynchronous active-low reset
//   in_data, in_valid, in_ready         : upstream transfer (in_ready is a function of state only)
//   out_data, out_valid, out_ready      : downstream transfer, out_data is the main register
module asic_dmux_skid
    import asic_dmux_pipe_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    skid_state_t   state_q;
    skid_state_t   state_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          push;
    logic          pop;
    logic          load_main;
    logic          load_skid;
    logic          promote;

    // Handshake outputs decode the state register only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    promote = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            // Data only moves on a load so out holds steady under backpressure.
            if (load_main) begin
                main_q <= in_data;
            end else if (promote) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/asic_dmux_pipe.sv
// rtl/asic_dmux_pipe.sv - N-way one-hot data mux with registered valid/ready output stage
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   bus (slave) : sel/in/in_valid/in_ready in, out/out_valid/out_ready out, err/err_clear
// Parameters: N channels (>=2), DW bits per channel, PROP cell-selection property string.
// Build option: ASIC_DMUX_PIPE_ONEHOT_CHECK_EN compiles in the sticky non-one-hot select
// error; without it err is tied low and err_clear is ignored.
module asic_dmux_pipe
    import asic_dmux_pipe_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 1,
    parameter     PROP = "DEFAULT"
) (
    input  logic            clk,
    input  logic            nreset,
    asic_dmux_pipe_if.slave bus
);

    if (N < 2 || N > ONEHOT_MAX_W || DW < 1 || $bits(PROP) < 8) begin : g_bad_cfg
        $error("asic_dmux_pipe: unsupported N/DW/PROP");
    end

    logic [DW-1:0] mux_data;

    // AND-OR mux: several selected channels OR together, no selection yields zero.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | ({DW{bus.sel[i]}} & bus.in[i*DW +: DW]);
        end
    end

    asic_dmux_skid #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .nreset    (nreset),
        .in_data   (mux_data),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (bus.out),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

`ifdef ASIC_DMUX_PIPE_ONEHOT_CHECK_EN
    logic xfer;
    logic sel_bad;
    logic err_q;

    assign xfer    = bus.in_valid & bus.in_ready;
    assign sel_bad = !is_onehot(ONEHOT_MAX_W'(bus.sel));
    assign bus.err = err_q;

    // A new error outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else if (xfer && sel_bad) begin
            err_q <= 1'b1;
        end else if (bus.err_clear) begin
            err_q <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (nreset && xfer) begin
            assert (!sel_bad)
                else $error("asic_dmux_pipe: non-one-hot sel %b accepted", bus.sel);
        end
    end
`endif
`else
    logic unused_err_clear;

    assign unused_err_clear = bus.err_clear;
    assign bus.err          = 1'b0;
`endif

endmodule
